// File: rtl/tt_mux_pkg.sv
// rtl/tt_mux_pkg.sv - shared widths, bus field offsets and FSM state type for the project mux controller
//
// Purpose: single home for the broadcast/return bus layout so the controller,
//          the bus interface and the bench agree on the bit positions.
// Ports:   none (package).
package tt_mux_pkg;

    localparam int IW_W  = 18;
    localparam int OW_W  = 24;
    localparam int PAD_W = 8;

    // iw = {uio_in, ui_in, rst_n, clk}
    localparam int IW_CLK_BIT   = 0;
    localparam int IW_RST_N_BIT = 1;
    localparam int IW_UI_LSB    = 2;
    localparam int IW_UIO_LSB   = 10;

    // ow slice = {uio_oe, uio_out, uo_out}
    localparam int OW_UO_LSB      = 0;
    localparam int OW_UIO_OUT_LSB = 8;
    localparam int OW_UIO_OE_LSB  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/tt_mux_if.sv
// rtl/tt_mux_if.sv - project bus between the mux controller and the project wrappers
//
// Purpose: bundles the broadcast bus, the one-hot enables and the
//          concatenated project return bus.
// Signals: iw     - broadcast {uio_in, ui_in, rst_n, clk} to every wrapper
//          ena    - one-hot wrapper enable, bit k to wrapper k
//          ow_all - concatenated wrapper outputs, slice k from wrapper k
// Modports: master (controller), slave (wrapper array).
interface tt_mux_if #(
    parameter int N_PROJ = 24
);
    import tt_mux_pkg::*;

    logic [IW_W-1:0]          iw;
    logic [N_PROJ-1:0]        ena;
    logic [OW_W*N_PROJ-1:0]   ow_all;

    modport master (
        output iw,
        output ena,
        input  ow_all
    );

    modport slave (
        input  iw,
        input  ena,
        output ow_all
    );

endinterface

// File: rtl/tt_mux_sync.sv
// rtl/tt_mux_sync.sv - two-flop synchronizer for one asynchronous pad
//
// Purpose: brings an asynchronous level into the clk domain.
// Ports:   clk - sampling clock
//          rst - synchronous active-high reset, clears both flops
//          d   - asynchronous input
//          q   - synchronized output, two clk edges behind d
module tt_mux_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tt_mux_ctrl.sv
// rtl/tt_mux_ctrl.sv - selection counter, enable FSM and output mux for the shared project bus
//
// Purpose: picks one of N_PROJ project wrappers from three slow pad
//          controls, holds its reset for HOLD_CYC cycles after enabling it,
//          then routes its outputs to the pads through a register.
// Ports:   clk, rst          - controller clock, synchronous active-high reset
//          sel_clr/inc/ena   - asynchronous selection pads
//          user_clk          - project clock pad, forwarded on iw
//          user_rst_n        - project reset pad, forwarded on iw in ACTIVE
//          ui_in, uio_in     - project input pads, forwarded on iw
//          bus               - project bus (iw, ena, ow_all), master side
//          uo_out/uio_out/uio_oe - registered outputs of the selected project
//          sel               - current selection
module tt_mux_ctrl
    import tt_mux_pkg::*;
#(
    parameter int N_PROJ   = 24,
    parameter int SEL_W    = 5,
    parameter int HOLD_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel_clr,
    input  logic              sel_inc,
    input  logic              sel_ena,
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [PAD_W-1:0]  ui_in,
    input  logic [PAD_W-1:0]  uio_in,
    tt_mux_if.master          bus,
    output logic [PAD_W-1:0]  uo_out,
    output logic [PAD_W-1:0]  uio_out,
    output logic [PAD_W-1:0]  uio_oe,
    output logic [SEL_W-1:0]  sel
);

    localparam int HC_W  = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC);
    localparam int IDX_W = $clog2(OW_W * N_PROJ);
    localparam logic [N_PROJ-1:0] ENA_ONE = N_PROJ'(1);

    logic clr_s;
    logic inc_s;
    logic ena_s;
    logic inc_d;
    logic inc_pulse;
    logic go;

    state_t          state;
    state_t          state_next;
    logic [HC_W-1:0] hold_cnt;
    logic [HC_W-1:0] hold_next;

    logic [SEL_W-1:0]  sel_q;
    logic [N_PROJ-1:0] ena_q;
    logic [OW_W-1:0]   out_q;
    logic [IDX_W-1:0]  base;
    logic [OW_W-1:0]   slice;
    logic [IW_W-1:0]   iw_w;

    tt_mux_sync u_sync_clr (.clk(clk), .rst(rst), .d(sel_clr), .q(clr_s));
    tt_mux_sync u_sync_inc (.clk(clk), .rst(rst), .d(sel_inc), .q(inc_s));
    tt_mux_sync u_sync_ena (.clk(clk), .rst(rst), .d(sel_ena), .q(ena_s));

    // One pulse per rising edge of the synchronized increment level.
    always_ff @(posedge clk) begin
        if (rst) begin
            inc_d <= 1'b0;
        end else begin
            inc_d <= inc_s;
        end
    end

    assign inc_pulse = inc_s & ~inc_d;

    // Any selection activity cancels the enable for this cycle, so a project
    // is never enabled while the selection is moving underneath it.
    assign go = ena_s & ~clr_s & ~inc_pulse;

    // Clear wins over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
        end else if (clr_s) begin
            sel_q <= '0;
        end else if (inc_pulse) begin
            if (sel_q == SEL_W'(N_PROJ - 1)) begin
                sel_q <= '0;
            end else begin
                sel_q <= sel_q + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
        end
    end

    // hold_cnt counts completed HOLD cycles; leaving HOLD always clears it.
    always_comb begin
        state_next = state;
        hold_next  = '0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!go) begin
                    state_next = ST_IDLE;
                end else if (hold_cnt == HC_W'(HOLD_CYC - 1)) begin
                    state_next = ST_ACTIVE;
                end else begin
                    hold_next = hold_cnt + HC_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (!go) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Enable is registered from the next state so it changes on the same
    // edge as the FSM; sel cannot move on any edge where the next state is
    // not IDLE, so sel_q is already the selection that will be enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            ena_q <= '0;
        end else if (state_next != ST_IDLE) begin
            ena_q <= ENA_ONE << sel_q;
        end else begin
            ena_q <= '0;
        end
    end

    assign base  = IDX_W'(sel_q) * IDX_W'(OW_W);
    assign slice = bus.ow_all[base +: OW_W];

    // Gated by the current state, so the register reads zero from the edge
    // after ACTIVE is left and shows the project one edge after entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else if (state == ST_ACTIVE) begin
            out_q <= slice;
        end else begin
            out_q <= '0;
        end
    end

    // Pure wiring: the project clock is forwarded without any retiming.
    always_comb begin
        iw_w                          = '0;
        iw_w[IW_CLK_BIT]              = user_clk;
        iw_w[IW_RST_N_BIT]            = (state == ST_ACTIVE) & user_rst_n;
        iw_w[IW_UI_LSB +: PAD_W]      = ui_in;
        iw_w[IW_UIO_LSB +: PAD_W]     = uio_in;
    end

    assign bus.iw  = iw_w;
    assign bus.ena = ena_q;

    assign uo_out  = out_q[OW_UO_LSB      +: PAD_W];
    assign uio_out = out_q[OW_UIO_OUT_LSB +: PAD_W];
    assign uio_oe  = out_q[OW_UIO_OE_LSB  +: PAD_W];
    assign sel     = sel_q;

endmodule

// File: doc/tt_mux_ctrl.md
TT_MUX_CTRL -- requirements
Module: tt_mux_ctrl

Interface
REQ-001 Parameter N_PROJ, default 24, number of project wrappers on the bus (range 2..32).
REQ-002 Parameter SEL_W, default 5, selection counter width; SHALL satisfy 2**SEL_W >= N_PROJ.
REQ-003 Parameter HOLD_CYC, default 4, number of clk cycles the project reset is held after enable.
REQ-004 clk  in  1  single controller clock; all state SHALL be clocked on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 sel_clr  in  1  asynchronous pad; level high clears the selection counter.
REQ-007 sel_inc  in  1  asynchronous pad; each rising edge advances the selection by one.
REQ-008 sel_ena  in  1  asynchronous pad; level high requests enabling the selected project.
REQ-009 user_clk  in  1  project clock from the pad.
REQ-010 user_rst_n  in  1  project reset from the pad, active-low.
REQ-011 ui_in  in  8  and uio_in  in  8: project input pads.
REQ-012 iw  out  18  broadcast project bus, packed {uio_in, ui_in, rst_n, clk}.
REQ-013 ena  out  N_PROJ  one-hot project enable, bit k to wrapper k.
REQ-014 ow_all  in  24*N_PROJ  concatenated project outputs; slice k = {uio_oe, uio_out, uo_out} of wrapper k.
REQ-015 uo_out  out  8, uio_out  out  8, uio_oe  out  8: registered outputs of the selected project.
REQ-016 sel  out  SEL_W  current selection, for debug.

Function
REQ-017 sel_clr, sel_inc and sel_ena SHALL each pass through a 2-flop synchronizer before use.
REQ-018 sel_inc rising edge SHALL be detected on the synchronized value, giving one pulse per edge.
REQ-019 The selection counter SHALL update on the 3rd clk edge after the pad change is first sampled.
REQ-020 Increment at sel = N_PROJ-1 SHALL wrap the counter to 0; sel SHALL never exceed N_PROJ-1.
REQ-021 Synchronized sel_clr high SHALL force sel = 0 and SHALL take priority over a simultaneous inc pulse.
REQ-022 FSM states: IDLE, HOLD, ACTIVE.
REQ-023 IDLE -> HOLD when synchronized sel_ena is high and neither clr nor an inc pulse is active that cycle.
REQ-024 HOLD -> ACTIVE after exactly HOLD_CYC cycles in HOLD.
REQ-025 HOLD or ACTIVE -> IDLE in the same cycle that synchronized sel_ena is low, clr is high, or an inc pulse occurs.
REQ-026 ena SHALL be all-zero in IDLE and SHALL equal one-hot(sel) in HOLD and ACTIVE; ena SHALL be registered.
REQ-027 iw.clk SHALL equal user_clk combinationally, without retiming.
REQ-028 iw.ui_in and iw.uio_in SHALL equal the pads combinationally.
REQ-029 iw.rst_n SHALL be 0 in IDLE and HOLD, and SHALL equal user_rst_n in ACTIVE.
REQ-030 In ACTIVE, the outputs SHALL show slice sel of ow_all with one clk cycle of register latency.
REQ-031 In IDLE and HOLD, uo_out, uio_out and uio_oe SHALL be 0, so all pads are inputs.
REQ-032 On leaving ACTIVE, the outputs SHALL read 0 from the next clk edge.

Reset
REQ-033 While rst is high, all of the following SHALL hold from the next edge: sel = 0, FSM = IDLE, hold counter = 0, synchronizers and edge detector = 0, ena = 0, registered outputs = 0.
REQ-034 Reset asserted mid-HOLD or mid-ACTIVE SHALL abort to IDLE with no extra ena cycle.
REQ-035 A sel_ena level already high when rst releases SHALL enter HOLD at the 3rd clk edge after release.

Structure
REQ-036 Package tt_mux_pkg SHALL hold the following:
- IW_W = 18 and OW_W = 24;
- the iw/ow field bit offsets;
- the FSM state enum.
REQ-037 One sub-module, tt_mux_sync (2-flop synchronizer), SHALL be instantiated once per asynchronous pad input.
REQ-038 The output multiplexer SHALL be an indexed part-select on sel, followed by the output register.

Verification
REQ-039 Reset release, then 3 sel_inc pulses -> sel = 3 and ena = 0.
REQ-040 N_PROJ = 24, sel = 23, one inc pulse -> sel = 0.
REQ-041 sel = 5, raise sel_ena -> sequence:
- ena = 0x000020 and iw.rst_n = 0 for 4 cycles;
- then ACTIVE, with iw.rst_n following user_rst_n;
- ow_all slice 5 = 0xA5C3F0 -> uo_out = 0xF0, uio_out = 0xC3, uio_oe = 0xA5 one cycle later.
REQ-042 In ACTIVE, one inc pulse -> sequence:
- same cycle: IDLE, ena = 0, outputs 0 on the next edge;
- sel = 6;
- with sel_ena still high: re-enters HOLD on the following cycle.
REQ-043 sel_clr and sel_inc edge synchronized in the same cycle at sel = 7 -> sel = 0.
REQ-044 rst pulsed in HOLD cycle 2 -> ena = 0 and FSM IDLE on the next edge; no ACTIVE state is reached.
